pu_fifo_multi: RTL and testbench

//  Multi-channel FIFO processing unit: CHANNELS independent circular queues of {attr,data} words sharing one write port and one read port.

---
 rtl/pu_fifo_multi_pkg.sv | 24 ++
 rtl/pu_fifo_channel.sv | 90 +++++++++
 rtl/pu_fifo_multi.sv | 81 ++++++++
 tb/tb_pu_fifo_multi.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pu_fifo_multi_pkg.sv
// Shared definitions for the multi-channel FIFO processing unit.
// Holds the attribute INVALID bit index and the derived-width helpers
// used by the top and the per-channel queue.
package pu_fifo_multi_pkg;

   // Attribute bit that marks a word as invalid (empty read or bad channel)
   localparam int ATTR_INVALID = 0;

   // Pointer width for a queue of 'size' entries
   function automatic int addr_width(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

   // Occupancy width: must represent 0..size inclusive
   function automatic int cnt_width(input int size);
      return $clog2(size + 1);
   endfunction

   // Channel select width; a single channel still gets a 1-bit select
   function automatic int ch_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/pu_fifo_channel.sv
// Purpose: single circular queue of {attr,data} words with status and sticky errors.
// Latency: head visible combinationally; a pushed word reaches the head one cycle later.
// Backpressure: none; push while full is dropped (overflow), pop while empty sets underflow.
module pu_fifo_channel
   import pu_fifo_multi_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ATTR_WIDTH = 4,
   parameter int FIFO_SIZE  = 8,
   parameter int ADDR_WIDTH = addr_width(FIFO_SIZE),
   parameter int CNT_WIDTH  = cnt_width(FIFO_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [ATTR_WIDTH-1:0] attr_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic                  clr_i,
   output logic [DATA_WIDTH-1:0] head_data_o,
   output logic [ATTR_WIDTH-1:0] head_attr_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [CNT_WIDTH-1:0]  level_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int WORD_W = ATTR_WIDTH + DATA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(FIFO_SIZE - 1);
   localparam logic [CNT_WIDTH-1:0]  LVL_FULL = CNT_WIDTH'(FIFO_SIZE);

   logic [WORD_W-1:0]     mem_q [FIFO_SIZE];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  level_q, level_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  do_push, do_pop;

   // Status derives only from the registered level so strobes never reach it
   assign full_o      = (level_q == LVL_FULL);
   assign empty_o     = (level_q == '0);
   assign level_o     = level_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = udf_q;
   assign {head_attr_o, head_data_o} = mem_q[rd_ptr_q];

   // Accept decisions, pointer/level updates and sticky flag next-state
   always_comb begin
      do_pop  = pop_i && !empty_o;
      // A pop in the same cycle frees a slot, so a full queue still accepts
      do_push = push_i && (!full_o || do_pop);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (do_pop && !do_push) level_d = level_q - 1'b1;

      // Clear first, then a same-cycle error event re-sets the flag
      ovf_d = (ovf_q && !clr_i) || (push_i && !do_push);
      udf_d = (udf_q && !clr_i) || (pop_i && empty_o);
   end

   // Control state with asynchronous reset; storage contents are not cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage write; no reset so it maps onto plain RAM/flops
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= {attr_i, data_i};
   end

endmodule

// File: rtl/pu_fifo_multi.sv
// Purpose: CHANNELS independent {attr,data} queues behind one write and one read port.
// Latency: read head is combinational (0 cycles); a pushed word is readable next cycle.
// Backpressure: none; full/empty/level are status only, drops and bad reads raise sticky flags.
module pu_fifo_multi
   import pu_fifo_multi_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ATTR_WIDTH = 4,
   parameter int FIFO_SIZE  = 8,
   parameter int CHANNELS   = 2,
   parameter int ADDR_WIDTH = addr_width(FIFO_SIZE),
   parameter int CNT_WIDTH  = cnt_width(FIFO_SIZE),
   parameter int CH_WIDTH   = ch_width(CHANNELS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic [ATTR_WIDTH-1:0]         attr_in,
   input  logic                          signal_wr,
   input  logic [CH_WIDTH-1:0]           signal_wr_ch,
   input  logic                          signal_oe,
   input  logic [CH_WIDTH-1:0]           signal_oe_ch,
   input  logic                          signal_clr,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic [ATTR_WIDTH-1:0]         attr_out,
   output logic [CHANNELS-1:0]           full,
   output logic [CHANNELS-1:0]           empty,
   output logic [CHANNELS*CNT_WIDTH-1:0] level,
   output logic [CHANNELS-1:0]           overflow,
   output logic [CHANNELS-1:0]           underflow
);

   logic [DATA_WIDTH-1:0] head_data_w [CHANNELS];
   logic [ATTR_WIDTH-1:0] head_attr_w [CHANNELS];

   // One queue per channel; a select outside 0..CHANNELS-1 matches no instance
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic push_w, pop_w;
      assign push_w = signal_wr && (signal_wr_ch == CH_WIDTH'(i));
      assign pop_w  = signal_oe && (signal_oe_ch == CH_WIDTH'(i));

      pu_fifo_channel #(
         .DATA_WIDTH (DATA_WIDTH),
         .ATTR_WIDTH (ATTR_WIDTH),
         .FIFO_SIZE  (FIFO_SIZE),
         .ADDR_WIDTH (ADDR_WIDTH),
         .CNT_WIDTH  (CNT_WIDTH)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .data_i      (data_in),
         .attr_i      (attr_in),
         .push_i      (push_w),
         .pop_i       (pop_w),
         .clr_i       (signal_clr),
         .head_data_o (head_data_w[i]),
         .head_attr_o (head_attr_w[i]),
         .full_o      (full[i]),
         .empty_o     (empty[i]),
         .level_o     (level[i*CNT_WIDTH +: CNT_WIDTH]),
         .overflow_o  (overflow[i]),
         .underflow_o (underflow[i])
      );
   end

   // Output mux: zero when not enabled, INVALID for empty or unknown channel
   always_comb begin
      data_out = '0;
      attr_out = '0;
      if (signal_oe) begin
         attr_out[ATTR_INVALID] = 1'b1;
         for (int i = 0; i < CHANNELS; i++) begin
            if ((signal_oe_ch == CH_WIDTH'(i)) && !empty[i]) begin
               data_out = head_data_w[i];
               attr_out = head_attr_w[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_pu_fifo_multi.sv
// Randomised plus directed bench for pu_fifo_multi (FIFO_SIZE=3, CHANNELS=2).
// Stimulus pushes expected outputs/status into a queue; a monitor pops and compares.
module tb_pu_fifo_multi;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int FS = 3;
   localparam int NC = 2;
   localparam int CW = 2;   // $clog2(FS+1)

   logic            clk = 1'b0;
   logic            rst;
   logic [DW-1:0]   data_in;
   logic [AW-1:0]   attr_in;
   logic            signal_wr;
   logic [0:0]      signal_wr_ch;
   logic            signal_oe;
   logic [0:0]      signal_oe_ch;
   logic            signal_clr;
   logic [DW-1:0]   data_out;
   logic [AW-1:0]   attr_out;
   logic [NC-1:0]   full, empty, overflow, underflow;
   logic [NC*CW-1:0] level;

   pu_fifo_multi #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .FIFO_SIZE(FS), .CHANNELS(NC)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .attr_in(attr_in),
      .signal_wr(signal_wr), .signal_wr_ch(signal_wr_ch),
      .signal_oe(signal_oe), .signal_oe_ch(signal_oe_ch), .signal_clr(signal_clr),
      .data_out(data_out), .attr_out(attr_out), .full(full), .empty(empty),
      .level(level), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW+DW-1:0] out;   // {attr_out, data_out}
      logic [11:0]      st;    // {full, empty, overflow, underflow, level}
   } exp_t;

   exp_t            exp_q[$];
   logic [AW+DW-1:0] mq [NC][$];   // reference queues, head at index 0
   logic [NC-1:0]   m_ovf, m_udf;
   int              checks = 0;
   int              passes = 0;

   function automatic logic [11:0] model_status();
      logic [NC-1:0] f, e;
      logic [NC*CW-1:0] l;
      for (int c = 0; c < NC; c++) begin
         f[c] = (mq[c].size() == FS);
         e[c] = (mq[c].size() == 0);
         l[c*CW +: CW] = CW'(mq[c].size());
      end
      return {f, e, m_ovf, m_udf, l};
   endfunction

   // One clock of stimulus: record what the DUT must show now, then advance the model
   task automatic cycle(input logic wr, input int wch, input logic [DW-1:0] d,
                        input logic [AW-1:0] a, input logic oe, input int och,
                        input logic clr);
      exp_t e;
      logic pop_ok, push_ok;
      @(posedge clk); #1;
      signal_wr = wr; signal_wr_ch = wch[0]; data_in = d; attr_in = a;
      signal_oe = oe; signal_oe_ch = och[0]; signal_clr = clr;

      e.out = '0;
      if (oe) e.out = (mq[och].size() == 0) ? {4'h1, 32'h0} : mq[och][0];
      e.st = model_status();
      exp_q.push_back(e);

      pop_ok  = oe && (mq[och].size() > 0);
      push_ok = wr && ((mq[wch].size() < FS) || (pop_ok && och == wch));
      if (clr) begin m_ovf = '0; m_udf = '0; end
      if (oe && mq[och].size() == 0) m_udf[och] = 1'b1;
      if (wr && !push_ok) m_ovf[wch] = 1'b1;
      if (pop_ok)  void'(mq[och].pop_front());
      if (push_ok) mq[wch].push_back({a, d});
   endtask

   task automatic idle();
      cycle(0, 0, '0, '0, 0, 0, 0);
   endtask

   task automatic push(input int ch, input logic [DW-1:0] d);
      cycle(1, ch, d, 4'h0, 0, 0, 0);
   endtask

   task automatic pop(input int ch);
      cycle(0, 0, '0, '0, 1, ch, 0);
   endtask

   // Monitor: compare outputs and status half a cycle after each stimulus
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({attr_out, data_out} !== e.out)
               $display("FAIL out t=%0t got=%h want=%h", $time, {attr_out, data_out}, e.out);
            else passes++;
            checks++;
            if ({full, empty, overflow, underflow, level} !== e.st)
               $display("FAIL status t=%0t got=%h want=%h", $time,
                        {full, empty, overflow, underflow, level}, e.st);
            else passes++;
         end
      end
   end

   initial begin
      rst = 1'b1;
      data_in = '0; attr_in = '0; signal_wr = 0; signal_wr_ch = '0;
      signal_oe = 0; signal_oe_ch = '0; signal_clr = 0;
      m_ovf = '0; m_udf = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle();                                   // reset state

      // 1: ordering, full/empty and pointer wrap over two rounds
      push(0, 32'hA); push(0, 32'hB); push(0, 32'hC);
      pop(0); pop(0); pop(0);
      push(0, 32'hD); push(0, 32'hE); push(0, 32'hF);
      pop(0); pop(0); pop(0); idle();

      // 2: overflow drops the word, originals survive, clear drops the flag
      push(0, 32'h1); push(0, 32'h2); push(0, 32'h3); push(0, 32'h99);
      pop(0); pop(0); pop(0);
      cycle(0, 0, '0, '0, 0, 0, 1); idle();

      // 3: pop from empty ch1
      pop(1); idle();

      // 4: same-cycle push+pop on full ch0, then on empty ch1
      push(0, 32'h10); push(0, 32'h11); push(0, 32'h12);
      cycle(1, 0, 32'h13, 4'h6, 1, 0, 0);
      cycle(1, 1, 32'h20, 4'h2, 1, 1, 0);
      idle();
      pop(0); pop(0); pop(0); pop(1); idle();

      // 5: cross-channel push/pop in the same cycle
      push(1, 32'h30);
      for (int i = 0; i < 4; i++) begin
         cycle(1, 0, 32'h40 + i, 4'h0, 1, 1, 0);
         cycle(1, 1, 32'h50 + i, 4'h8, 1, 0, 0);
      end
      pop(0); pop(1); pop(1); idle();

      // 6: asynchronous reset mid-cycle with ch0 at level 2
      cycle(0, 0, '0, '0, 0, 0, 1);
      push(0, 32'h77); push(0, 32'h78); idle();
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      checks++;
      if (empty !== 2'b11) $display("FAIL async_empty got=%b want=11", empty);
      else passes++;
      checks++;
      if (level !== '0) $display("FAIL async_level got=%h want=0", level);
      else passes++;
      for (int c = 0; c < NC; c++) mq[c].delete();
      m_ovf = '0; m_udf = '0;
      @(posedge clk); #1 rst = 1'b0;
      pop(0); idle();

      // Randomised traffic with occasional clears
      for (int n = 0; n < 600; n++)
         cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom, 4'($urandom),
               $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 9) == 0));
      idle();

      repeat (4) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) $display("FAIL drain got=%0d want=0", exp_q.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
